// File: rtl/eth_udp_framer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : eth_udp_framer_pkg
// Brief    : Shared header offsets, fixed overheads and FSM encoding for the
//            Ethernet/UDP framer.
// Revision : 1.0
// ============================================================================
package eth_udp_framer_pkg;

    localparam int IP_HDR_OFS       = 14;
    localparam int IP_LEN_OFS       = 16;
    localparam int CSUM_OFS         = 24;
    localparam int UDP_LEN_OFS      = 38;
    localparam int IP_HDR_HALFWORDS = 10;

    localparam int UDP_OVH = 8;
    localparam int IP_OVH  = 28;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_CSUM = 3'd1,
        S_HDR  = 3'd2,
        S_PAY  = 3'd3,
        S_DONE = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/eth_udp_framer_csum.sv
`default_nettype none
// ============================================================================
// Module   : ipv4_csum
// Brief    : Ones-complement halfword accumulator with a double carry fold.
// Revision : 1.0
// ============================================================================
module ipv4_csum (
    input  logic        clk_ext,
    input  logic        rst,
    input  logic        i_clear,
    input  logic        i_acc,
    input  logic        i_fold,
    input  logic [15:0] i_hw,
    output logic [15:0] o_csum
);

    logic [19:0] r_acc;
    logic [16:0] w_fold1;
    logic [15:0] w_fold2;

    // Ten halfwords fit in 20 bits; two folds always absorb every carry.
    assign w_fold1 = {1'b0, r_acc[15:0]} + {13'd0, r_acc[19:16]};
    assign w_fold2 = w_fold1[15:0] + {15'd0, w_fold1[16]};

    always_ff @(posedge clk_ext) begin
        if (rst || i_clear) begin
            r_acc <= '0;
        end else if (i_acc) begin
            r_acc <= r_acc + {4'd0, i_hw};
        end else if (i_fold) begin
            r_acc <= {4'd0, w_fold2};
        end
    end

    assign o_csum = ~r_acc[15:0];

endmodule
`default_nettype wire

// File: rtl/eth_udp_framer.sv
`default_nettype none
// ============================================================================
// Module   : eth_udp_framer
// Brief    : Template-driven Ethernet/IPv4/UDP framer with computed lengths,
//            IPv4 header checksum and a backpressured 8-bit LocalLink output.
// Revision : 1.0
// ============================================================================
module eth_udp_framer
    import eth_udp_framer_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int LEN_W     = 11,
    parameter int HDR_BYTES = 44,
    parameter int PAD_BYTES = 2
) (
    input  logic              clk_ext,
    input  logic              rst,
    input  logic              hdr_we,
    input  logic [5:0]        hdr_addr,
    input  logic [7:0]        hdr_din,
    output logic              hdr_wr_err,
    input  logic              pkt_start,
    input  logic [LEN_W-1:0]  pkt_words,
    output logic              pkt_busy,
    output logic              pkt_done,
    output logic [15:0]       pkt_count,
    input  logic [DATA_W-1:0] pay_data,
    input  logic              pay_valid,
    output logic              pay_ready,
    output logic [7:0]        tx_data,
    output logic              tx_sof_n,
    output logic              tx_eof_n,
    output logic              tx_src_rdy_n,
    input  logic              tx_dst_rdy_n
);

    localparam logic [3:0]  c_WB4        = 4'(DATA_W / 8);
    localparam logic [15:0] c_WB16       = 16'(DATA_W / 8);
    localparam logic [5:0]  c_HDR_LAST   = 6'(HDR_BYTES - 1);
    localparam logic [3:0]  c_FOLD_CNT   = 4'(IP_HDR_HALFWORDS);
    localparam logic [3:0]  c_HW_IPLEN   = 4'((IP_LEN_OFS - IP_HDR_OFS) / 2);
    localparam logic [3:0]  c_HW_CSUM    = 4'((CSUM_OFS - IP_HDR_OFS) / 2);
    localparam logic [5:0]  c_IP_HDR_OFS = 6'(IP_HDR_OFS);
    localparam logic [5:0]  c_IPLEN_OFS  = 6'(IP_LEN_OFS);
    localparam logic [5:0]  c_CSUM_OFS   = 6'(CSUM_OFS);
    localparam logic [5:0]  c_UDPLEN_OFS = 6'(UDP_LEN_OFS);
    localparam logic [15:0] c_IP_ADD     = 16'(IP_OVH + PAD_BYTES);
    localparam logic [15:0] c_UDP_ADD    = 16'(UDP_OVH + PAD_BYTES);

    logic [7:0]        r_tmpl [HDR_BYTES];

    state_t            r_state;
    state_t            w_next_state;
    logic [3:0]        r_cnt;
    logic [5:0]        r_idx;
    logic [LEN_W-1:0]  r_words_left;
    logic              r_has_pay;
    logic [15:0]       r_ip_len;
    logic [15:0]       r_udp_len;
    logic [DATA_W-1:0] r_sh;
    logic [3:0]        r_sh_cnt;

    logic              r_busy;
    logic              r_done;
    logic [15:0]       r_count;
    logic              r_wr_err;

    logic [7:0]        r_tx_data;
    logic              r_tx_sof_n;
    logic              r_tx_eof_n;
    logic              r_tx_src_rdy_n;

    logic [15:0]       w_p;
    logic              w_start;
    logic              w_csum_acc;
    logic              w_csum_fold;
    logic [5:0]        w_hw_addr;
    logic [15:0]       w_csum_hw;
    logic [15:0]       w_csum;
    logic [7:0]        w_hdr_byte;
    logic              w_slot_free;
    logic              w_eof_xfer;
    logic              w_hdr_load;
    logic              w_sh_load;
    logic              w_pay_ready;
    logic              w_pay_acc;

    assign w_p         = 16'(pkt_words) * c_WB16;
    assign w_start     = (r_state == S_IDLE) && pkt_start;
    assign w_csum_acc  = (r_state == S_CSUM) && (r_cnt < c_FOLD_CNT);
    assign w_csum_fold = (r_state == S_CSUM) && (r_cnt == c_FOLD_CNT);

    // The output byte register may be reloaded when empty or when its byte is leaving.
    assign w_slot_free = r_tx_src_rdy_n || !tx_dst_rdy_n;
    assign w_eof_xfer  = !r_tx_src_rdy_n && !tx_dst_rdy_n && !r_tx_eof_n;

    // Byte 0 is loaded during the fold cycle so SOF appears 12 cycles after start.
    assign w_hdr_load  = w_slot_free &&
                         (w_csum_fold || ((r_state == S_HDR) && (r_idx <= c_HDR_LAST)));
    assign w_sh_load   = (r_state == S_PAY) && (r_sh_cnt != 4'd0) && w_slot_free;
    assign w_pay_ready = (r_state == S_PAY) && (r_words_left != '0) &&
                         ((r_sh_cnt == 4'd0) || ((r_sh_cnt == 4'd1) && w_slot_free));
    assign w_pay_acc   = w_pay_ready && pay_valid;

    always_ff @(posedge clk_ext) begin
        if (hdr_we && !r_busy && (hdr_addr <= c_HDR_LAST)) begin
            r_tmpl[hdr_addr] <= hdr_din;
        end
    end

    assign w_hw_addr = c_IP_HDR_OFS + {1'b0, r_cnt, 1'b0};

    always_comb begin
        w_csum_hw = {r_tmpl[w_hw_addr], r_tmpl[w_hw_addr + 6'd1]};
        if (r_cnt == c_HW_IPLEN) begin
            w_csum_hw = r_ip_len;
        end else if (r_cnt == c_HW_CSUM) begin
            w_csum_hw = 16'h0000;
        end
    end

    ipv4_csum u_csum (
        .clk_ext (clk_ext),
        .rst     (rst),
        .i_clear (w_start),
        .i_acc   (w_csum_acc),
        .i_fold  (w_csum_fold),
        .i_hw    (w_csum_hw),
        .o_csum  (w_csum)
    );

    always_comb begin
        w_hdr_byte = r_tmpl[r_idx];
        if (r_idx == c_IPLEN_OFS) begin
            w_hdr_byte = r_ip_len[15:8];
        end else if (r_idx == c_IPLEN_OFS + 6'd1) begin
            w_hdr_byte = r_ip_len[7:0];
        end else if (r_idx == c_CSUM_OFS) begin
            w_hdr_byte = w_csum[15:8];
        end else if (r_idx == c_CSUM_OFS + 6'd1) begin
            w_hdr_byte = w_csum[7:0];
        end else if (r_idx == c_UDPLEN_OFS) begin
            w_hdr_byte = r_udp_len[15:8];
        end else if (r_idx == c_UDPLEN_OFS + 6'd1) begin
            w_hdr_byte = r_udp_len[7:0];
        end
    end

    always_ff @(posedge clk_ext) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    w_next_state = S_CSUM;
                end
            end
            S_CSUM: begin
                if (w_csum_fold) begin
                    w_next_state = S_HDR;
                end
            end
            S_HDR: begin
                if (w_hdr_load && (r_idx == c_HDR_LAST) && r_has_pay) begin
                    w_next_state = S_PAY;
                end else if (w_eof_xfer) begin
                    w_next_state = S_DONE;
                end
            end
            S_PAY: begin
                if (w_eof_xfer) begin
                    w_next_state = S_DONE;
                end
            end
            S_DONE: begin
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_ext) begin
        if (rst) begin
            r_cnt        <= '0;
            r_idx        <= '0;
            r_words_left <= '0;
            r_has_pay    <= 1'b0;
            r_ip_len     <= '0;
            r_udp_len    <= '0;
        end else if (w_start) begin
            r_cnt        <= '0;
            r_idx        <= '0;
            r_words_left <= pkt_words;
            r_has_pay    <= (pkt_words != '0);
            r_ip_len     <= w_p + c_IP_ADD;
            r_udp_len    <= w_p + c_UDP_ADD;
        end else begin
            if (r_state == S_CSUM) begin
                r_cnt <= r_cnt + 4'd1;
            end
            if (w_hdr_load) begin
                r_idx <= r_idx + 6'd1;
            end
            if (w_pay_acc) begin
                r_words_left <= r_words_left - 1'b1;
            end
        end
    end

    // A newly accepted word replaces the shifter only once its last byte has left.
    always_ff @(posedge clk_ext) begin
        if (rst) begin
            r_sh     <= '0;
            r_sh_cnt <= '0;
        end else if (w_pay_acc) begin
            r_sh     <= pay_data;
            r_sh_cnt <= c_WB4;
        end else if (w_sh_load) begin
            r_sh     <= r_sh << 8;
            r_sh_cnt <= r_sh_cnt - 4'd1;
        end
    end

    always_ff @(posedge clk_ext) begin
        if (rst) begin
            r_tx_data      <= '0;
            r_tx_sof_n     <= 1'b1;
            r_tx_eof_n     <= 1'b1;
            r_tx_src_rdy_n <= 1'b1;
        end else if (w_hdr_load) begin
            r_tx_data      <= w_hdr_byte;
            r_tx_sof_n     <= (r_idx != 6'd0);
            r_tx_eof_n     <= !((r_idx == c_HDR_LAST) && !r_has_pay);
            r_tx_src_rdy_n <= 1'b0;
        end else if (w_sh_load) begin
            r_tx_data      <= r_sh[DATA_W-1 -: 8];
            r_tx_sof_n     <= 1'b1;
            r_tx_eof_n     <= !((r_sh_cnt == 4'd1) && (r_words_left == '0));
            r_tx_src_rdy_n <= 1'b0;
        end else if (w_slot_free) begin
            r_tx_sof_n     <= 1'b1;
            r_tx_eof_n     <= 1'b1;
            r_tx_src_rdy_n <= 1'b1;
        end
    end

    always_ff @(posedge clk_ext) begin
        if (rst) begin
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_count  <= '0;
            r_wr_err <= 1'b0;
        end else begin
            r_wr_err <= hdr_we && (r_busy || (hdr_addr > c_HDR_LAST));
            r_done   <= w_eof_xfer;
            if (w_eof_xfer) begin
                r_count <= r_count + 16'd1;
            end
            if (w_start) begin
                r_busy <= 1'b1;
            end else if (r_state == S_DONE) begin
                r_busy <= 1'b0;
            end
        end
    end

    assign hdr_wr_err   = r_wr_err;
    assign pkt_busy     = r_busy;
    assign pkt_done     = r_done;
    assign pkt_count    = r_count;
    assign pay_ready    = w_pay_ready;
    assign tx_data      = r_tx_data;
    assign tx_sof_n     = r_tx_sof_n;
    assign tx_eof_n     = r_tx_eof_n;
    assign tx_src_rdy_n = r_tx_src_rdy_n;

endmodule
`default_nettype wire

// File: tb/tb_eth_udp_framer.sv
`default_nettype none
// ============================================================================
// Module   : tb_eth_udp_framer
// Brief    : Directed self-checking bench for eth_udp_framer.
// Revision : 1.0
// ============================================================================
module tb_eth_udp_framer;

    localparam int DATA_W    = 32;
    localparam int LEN_W     = 11;
    localparam int HDR_BYTES = 44;
    localparam int PAD_BYTES = 2;

    logic              clk_ext = 1'b0;
    logic              rst = 1'b1;
    logic              hdr_we = 1'b0;
    logic [5:0]        hdr_addr = '0;
    logic [7:0]        hdr_din = '0;
    logic              hdr_wr_err;
    logic              pkt_start = 1'b0;
    logic [LEN_W-1:0]  pkt_words = '0;
    logic              pkt_busy;
    logic              pkt_done;
    logic [15:0]       pkt_count;
    logic [DATA_W-1:0] pay_data = '0;
    logic              pay_valid = 1'b0;
    logic              pay_ready;
    logic [7:0]        tx_data;
    logic              tx_sof_n;
    logic              tx_eof_n;
    logic              tx_src_rdy_n;
    logic              tx_dst_rdy_n = 1'b0;

    eth_udp_framer #(
        .DATA_W    (DATA_W),
        .LEN_W     (LEN_W),
        .HDR_BYTES (HDR_BYTES),
        .PAD_BYTES (PAD_BYTES)
    ) dut (
        .clk_ext      (clk_ext),
        .rst          (rst),
        .hdr_we       (hdr_we),
        .hdr_addr     (hdr_addr),
        .hdr_din      (hdr_din),
        .hdr_wr_err   (hdr_wr_err),
        .pkt_start    (pkt_start),
        .pkt_words    (pkt_words),
        .pkt_busy     (pkt_busy),
        .pkt_done     (pkt_done),
        .pkt_count    (pkt_count),
        .pay_data     (pay_data),
        .pay_valid    (pay_valid),
        .pay_ready    (pay_ready),
        .tx_data      (tx_data),
        .tx_sof_n     (tx_sof_n),
        .tx_eof_n     (tx_eof_n),
        .tx_src_rdy_n (tx_src_rdy_n),
        .tx_dst_rdy_n (tx_dst_rdy_n)
    );

    always #5 clk_ext = ~clk_ext;

    int total = 0;
    int bad   = 0;

    logic [7:0] tmpl_m [0:43] = '{
        8'h00, 8'h0A, 8'h35, 8'h01, 8'h02, 8'h03, 8'h00, 8'h0A, 8'h35, 8'h04, 8'h05, 8'h06,
        8'h08, 8'h00,
        8'h45, 8'h00, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h40, 8'h00, 8'h40, 8'h11, 8'h12, 8'h34,
        8'hC0, 8'hA8, 8'h0A, 8'h01, 8'hC0, 8'hA8, 8'h0A, 8'h02,
        8'h04, 8'h00, 8'h04, 8'h01, 8'hEE, 8'hEE, 8'h00, 8'h00,
        8'h5A, 8'hA5
    };

    logic [7:0] rx [$];
    int sof_cnt, sof_pos, eof_pos, first_cyc, hold_bad, idle_cnt, pr_cnt, err_cnt;
    int exp_cnt = 0;
    bit finished;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] m_len(input int words, input int ovh);
        return 16'(words * 4 + ovh + PAD_BYTES);
    endfunction

    function automatic logic [15:0] m_csum(input int words);
        logic [31:0] s;
        logic [15:0] hw;
        s = 0;
        for (int k = 0; k < 10; k++) begin
            hw = {tmpl_m[14 + 2 * k], tmpl_m[15 + 2 * k]};
            if (k == 1) hw = m_len(words, 28);
            if (k == 5) hw = 16'h0000;
            s = s + {16'd0, hw};
        end
        s = {16'd0, s[15:0]} + {16'd0, s[31:16]};
        s = {16'd0, s[15:0]} + {16'd0, s[31:16]};
        return ~s[15:0];
    endfunction

    function automatic logic [7:0] m_byte(input int i, input int words, input logic [15:0] cs);
        logic [15:0] ipl;
        logic [15:0] udl;
        ipl = m_len(words, 28);
        udl = m_len(words, 8);
        case (i)
            16:      return ipl[15:8];
            17:      return ipl[7:0];
            24:      return cs[15:8];
            25:      return cs[7:0];
            38:      return udl[15:8];
            39:      return udl[7:0];
            default: return (i < 44) ? tmpl_m[i] : 8'(i - 44);
        endcase
    endfunction

    task automatic wr(input logic [5:0] a, input logic [7:0] d);
        hdr_we   = 1'b1;
        hdr_addr = a;
        hdr_din  = d;
        @(posedge clk_ext); #1;
        hdr_we   = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_data"}, 32'(tx_data), 0);
        check({tag, "_sof"},  32'(tx_sof_n), 1);
        check({tag, "_eof"},  32'(tx_eof_n), 1);
        check({tag, "_src"},  32'(tx_src_rdy_n), 1);
        check({tag, "_prdy"}, 32'(pay_ready), 0);
        check({tag, "_busy"}, 32'(pkt_busy), 0);
        check({tag, "_done"}, 32'(pkt_done), 0);
        check({tag, "_err"},  32'(hdr_wr_err), 0);
        check({tag, "_cnt"},  32'(pkt_count), 0);
    endtask

    // One packet: request at cycle 0, then feed payload and sink bytes until EOF.
    task automatic run_pkt(input int words, input bit stall, input int gap, input bit busy_wr,
                           input bit dup_start, input int abort_at, input int wr0_addr,
                           input logic [7:0] wr0_data);
        int cyc, wk, gapc;
        bit stalled;
        logic [7:0] s_data;
        logic s_sof, s_eof, s_src;
        rx.delete();
        sof_cnt = 0; sof_pos = -1; eof_pos = -1; first_cyc = -1;
        hold_bad = 0; idle_cnt = 0; pr_cnt = 0; err_cnt = 0; finished = 0;
        stalled = 0; s_data = '0; s_sof = 1'b1; s_eof = 1'b1; s_src = 1'b1;
        pkt_start = 1'b1;
        pkt_words = LEN_W'(words);
        if (wr0_addr >= 0) begin
            hdr_we = 1'b1; hdr_addr = 6'(wr0_addr); hdr_din = wr0_data;
        end
        @(posedge clk_ext); #1;
        pkt_start = 1'b0;
        hdr_we = 1'b0;
        cyc = 1; wk = 0; gapc = 0;
        while (!finished && cyc < 20000) begin
            if (abort_at >= 0 && rx.size() == 44 + abort_at) begin
                rst = 1'b1; pay_valid = 1'b0; tx_dst_rdy_n = 1'b0;
                @(posedge clk_ext); #1;
                check_reset_outputs("abort");
                rst = 1'b0;
                exp_cnt = 0;
                return;
            end
            tx_dst_rdy_n = stall ? 1'($urandom_range(0, 1)) : 1'b0;
            if (busy_wr) begin
                hdr_we = (cyc == 5); hdr_addr = 6'd0; hdr_din = 8'hAA;
            end
            if (dup_start) pkt_start = (cyc >= 2 && cyc <= 5);
            pay_valid = (wk < words) && (gapc == 0);
            pay_data  = {8'(4 * wk), 8'(4 * wk + 1), 8'(4 * wk + 2), 8'(4 * wk + 3)};
            #1;
            if (hdr_wr_err) err_cnt++;
            if (pay_ready) pr_cnt++;
            if (stalled && (tx_data !== s_data || tx_sof_n !== s_sof ||
                            tx_eof_n !== s_eof || tx_src_rdy_n !== s_src)) hold_bad++;
            if (!tx_src_rdy_n && first_cyc < 0) first_cyc = cyc;
            if (tx_src_rdy_n && rx.size() > 0) idle_cnt++;
            if (!tx_src_rdy_n && !tx_dst_rdy_n) begin
                rx.push_back(tx_data);
                if (!tx_sof_n) begin
                    sof_cnt++;
                    sof_pos = rx.size() - 1;
                end
                if (!tx_eof_n) begin
                    eof_pos = rx.size() - 1;
                    finished = 1;
                end
            end
            stalled = !tx_src_rdy_n && tx_dst_rdy_n;
            s_data = tx_data; s_sof = tx_sof_n; s_eof = tx_eof_n; s_src = tx_src_rdy_n;
            if (pay_valid && pay_ready) begin
                wk++;
                gapc = gap;
            end else if (gapc > 0) begin
                gapc--;
            end
            if (!finished) begin
                @(posedge clk_ext); #1;
                cyc++;
            end
        end
        check("eof_seen", 32'(finished), 1);
        @(posedge clk_ext); #1;
        hdr_we = 1'b0; pkt_start = 1'b0; pay_valid = 1'b0;
        check("done_pulse", 32'(pkt_done), 1);
        check("busy_in_done", 32'(pkt_busy), 1);
        exp_cnt++;
        check("pkt_count", 32'(pkt_count), 32'(exp_cnt));
        @(posedge clk_ext); #1;
        check("done_low", 32'(pkt_done), 0);
        check("busy_low", 32'(pkt_busy), 0);
    endtask

    task automatic verify(input string tag, input int words);
        int nbad;
        logic [15:0] cs;
        nbad = 0;
        cs = m_csum(words);
        for (int i = 0; i < rx.size(); i++) begin
            if (rx[i] !== m_byte(i, words, cs)) nbad++;
        end
        check({tag, "_len"},   32'(rx.size()), 32'(44 + 4 * words));
        check({tag, "_eof"},   32'(eof_pos), 32'(43 + 4 * words));
        check({tag, "_sofn"},  32'(sof_cnt), 1);
        check({tag, "_sofp"},  32'(sof_pos), 0);
        check({tag, "_bytes"}, 32'(nbad), 0);
        check({tag, "_hold"},  32'(hold_bad), 0);
    endtask

    initial begin
        repeat (3) @(posedge clk_ext);
        #1;
        rst = 1'b0;
        @(posedge clk_ext); #1;
        check_reset_outputs("rst");

        for (int i = 0; i < 44; i++) wr(6'(i), tmpl_m[i]);

        // Large frame with hand-computed header fields.
        run_pkt(256, 0, 0, 0, 0, -1, -1, 8'h00);
        verify("big", 256);
        check("big_lat",  32'(first_cyc), 12);
        check("big_b16",  32'(rx[16]), 32'h04);
        check("big_b17",  32'(rx[17]), 32'h1E);
        check("big_b24",  32'(rx[24]), 32'hA1);
        check("big_b25",  32'(rx[25]), 32'h7B);
        check("big_b38",  32'(rx[38]), 32'h04);
        check("big_b39",  32'(rx[39]), 32'h0A);

        // Header-only frame.
        run_pkt(0, 0, 0, 0, 0, -1, -1, 8'h00);
        verify("zero", 0);
        check("zero_b16",  32'(rx[16]), 32'h00);
        check("zero_b17",  32'(rx[17]), 32'h1E);
        check("zero_b24",  32'(rx[24]), 32'hA5);
        check("zero_b25",  32'(rx[25]), 32'h7B);
        check("zero_b38",  32'(rx[38]), 32'h00);
        check("zero_b39",  32'(rx[39]), 32'h0A);
        check("zero_prdy", 32'(pr_cnt), 0);

        // Random sink stalls, with ignored start requests while busy.
        run_pkt(20, 1, 0, 0, 1, -1, -1, 8'h00);
        verify("stall", 20);

        // Source gaps of three cycles after every word.
        run_pkt(8, 0, 3, 0, 0, -1, -1, 8'h00);
        verify("gap", 8);
        check("gap_idle", 32'(idle_cnt > 0), 1);

        // Template writes: dropped while busy, accepted when idle, range checked.
        run_pkt(6, 0, 0, 1, 0, -1, -1, 8'h00);
        verify("busywr", 6);
        check("busywr_err", 32'(err_cnt), 1);
        wr(6'd0, 8'hAB);
        tmpl_m[0] = 8'hAB;
        check("idlewr_err", 32'(hdr_wr_err), 0);
        wr(6'd50, 8'h77);
        check("rangewr_err", 32'(hdr_wr_err), 1);
        @(posedge clk_ext); #1;
        check("rangewr_clr", 32'(hdr_wr_err), 0);
        tmpl_m[15] = 8'h10;
        run_pkt(2, 0, 0, 0, 0, -1, 15, 8'h10);
        verify("newtmpl", 2);
        check("newtmpl_b0", 32'(rx[0]), 32'hAB);

        // Reset in mid-payload, then a clean frame.
        run_pkt(40, 0, 0, 0, 0, 100, -1, 8'h00);
        check("abort_nofull", 32'(finished), 0);
        run_pkt(4, 0, 0, 0, 0, -1, -1, 8'h00);
        verify("after_rst", 4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/eth_udp_framer.md
Name: eth_udp_framer

Overview:
- Single-clock successor to the fixed-size Ethernet/UDP packet writer.
- Holds a writable 44-byte header template and accepts a word-wide payload stream.
- Computes IP total length, UDP length and the IPv4 header checksum per packet for any payload length; no per-size lookup tables.
- Emits an 8-bit LocalLink frame with full destination backpressure. Sits between the processing datapath and the Ethernet MAC TX client.

Parameters:
DATA_W, 32, payload word width in bits; multiple of 8, range 8..64
LEN_W, 11, width of payload length in words
HDR_BYTES, 44, template size: 14 Eth + 20 IP + 8 UDP + PAD_BYTES
PAD_BYTES, 2, alignment filler at end of template, counted as UDP payload

Ports:
clk_ext  in  1  clock; all logic in this domain
rst  in  1  reset rst, synchronous, active-high
hdr_we  in  1  template byte write enable
hdr_addr  in  6  template byte address, 0..HDR_BYTES-1
hdr_din  in  8  template byte data
hdr_wr_err  out  1  1-cycle pulse when a write is dropped
pkt_start  in  1  request a packet; sampled only in IDLE
pkt_words  in  LEN_W  payload length in DATA_W words, latched with pkt_start
pkt_busy  out  1  high from accepted pkt_start until the cycle after the EOF transfer
pkt_done  out  1  1-cycle pulse on the EOF transfer
pkt_count  out  16  count of completed frames, wraps at 0xFFFF
pay_data  in  DATA_W  payload word, MSB byte sent first
pay_valid  in  1  payload word valid
pay_ready  out  1  payload word accepted when pay_valid & pay_ready
tx_data  out  8  frame byte
tx_sof_n  out  1  start of frame, active low
tx_eof_n  out  1  end of frame, active low
tx_src_rdy_n  out  1  tx_data valid, active low
tx_dst_rdy_n  in  1  sink ready, active low; a byte transfers when src_rdy_n=0 and dst_rdy_n=0

Behaviour:
- Reset values: tx_data=0, tx_sof_n=1, tx_eof_n=1, tx_src_rdy_n=1, pay_ready=0, pkt_busy=0, pkt_done=0, hdr_wr_err=0, pkt_count=0, state=IDLE. Template contents are not cleared.
- Reset mid-packet: reset values apply on the next edge; the frame is abandoned (no EOF); unconsumed payload is left in the source.
- Template writes:
  - Accepted only while pkt_busy=0.
  - Write while busy, or hdr_addr>=HDR_BYTES: dropped, hdr_wr_err pulses.
  - pkt_start and a write in the same IDLE cycle: the write lands first; the packet uses the new byte.
- Length rules (16-bit, modulo 2^16):
  - P = pkt_words*DATA_W/8
  - UDP_LEN = P+8+PAD_BYTES, substituted at bytes 38,39
  - IP_LEN = P+28+PAD_BYTES, substituted at bytes 16,17
  - All multi-byte fields are big-endian.
- Checksum:
  - Ones-complement sum of the 10 big-endian halfwords at bytes 14..33, using substituted IP_LEN and treating bytes 24,25 as 0.
  - Fold carries twice, invert, substitute at bytes 24,25.
  - The template itself is never modified.
- State machine:
  - IDLE: pkt_start -> latch lengths, pkt_busy=1 -> CSUM.
  - CSUM: 1 halfword/cycle for 10 cycles, then 1 fold cycle -> HDR. Latency from pkt_start to first SOF byte valid = 12 cycles.
  - HDR: present bytes 0..HDR_BYTES-1 with substitutions. tx_sof_n=0 with byte 0 only. Advance only on transfer. After the last header byte: PAY if pkt_words>0, else that byte carries tx_eof_n=0 -> DONE.
  - PAY: pay_ready=1 only when the shift register is empty or its last byte is transferring. Bytes are sent MSB-first. If no word is available, tx_src_rdy_n=1 (gap), no data loss. The final payload byte carries tx_eof_n=0 -> DONE.
  - DONE: pkt_done pulse, pkt_count++, pkt_busy=0 next cycle -> IDLE.
- Held outputs: tx_data, sof, eof and src_rdy hold stable while tx_dst_rdy_n=1.
- pkt_start while busy is ignored (not queued).

Decomposition:
- Package eth_udp_framer_pkg: byte offsets (IP_LEN_OFS=16, CSUM_OFS=24, UDP_LEN_OFS=38, IP_HDR_OFS=14, IP_HDR_HALFWORDS=10), fixed overheads (UDP_OVH=8, IP_OVH=28), state enum.
- One sub-module: ipv4_csum (clear/accumulate/fold/result; 20-bit accumulator, 16-bit result).

Test Plan:
1. Template IP header 45 00 xx xx 00 00 40 00 40 11 00 00 C0 A8 0A 01 C0 A8 0A 02, DATA_W=32, pkt_words=256 -> bytes16,17=04 1E; bytes38,39=04 0A; bytes24,25=A1 7B; 44+1024=1068 bytes; SOF on byte 0, EOF on byte 1067; pkt_count=1.
2. pkt_words=0 -> 44-byte frame; EOF on byte 43; IP_LEN=0x001E, UDP_LEN=0x000A; pay_ready never asserted.
3. tx_dst_rdy_n toggled pseudo-randomly at 50% with payload words 0x00010203 ascending -> byte stream 00 01 02 03 04... with no drops or duplicates; outputs held during stalls.
4. pay_valid gapped 3 cycles every word -> src_rdy_n=1 during gaps; byte order intact; exact frame length.
5. Template write during busy -> hdr_wr_err pulse; frame unchanged. Next packet uses only writes made while idle. hdr_addr=50 -> hdr_wr_err pulse.
6. rst asserted on payload byte 100 -> next cycle all outputs at reset values; a new pkt_start then produces a correct full frame with SOF.
